// File: rtl/hex_display_scanner.sv
// Feeds per-digit seven-segment decoders with 5-bit codes (bit 4 = blank,
// bits 3:0 = hex value). A word accepted over valid/ready is scanned MSB
// first to apply leading-zero blanking, then swapped into the display
// register in a single edge. Global enable and blink masking act only on
// the registered output stage.
module hex_display_scanner #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  input  logic                    lz_blank_en,
  input  logic                    blink_en,
  input  logic                    disp_on,
  output logic [5*NUM_DIGITS-1:0] digit_codes,
  output logic                    busy
);

  localparam int unsigned DW    = 4 * NUM_DIGITS;
  localparam int unsigned CW    = 5 * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(BLINK_DIV);

  localparam logic [4:0]       BLANK     = 5'b10000;
  localparam logic [CW-1:0]    BLANK_ALL = {NUM_DIGITS{BLANK}};
  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t           state_q;
  logic [DW-1:0]    shadow_q;
  logic             lz_q;
  logic [IDX_W-1:0] idx_q;
  logic             seen_nz_q;
  logic [CW-1:0]    staging_q;
  logic [CW-1:0]    display_q;
  logic [CW-1:0]    codes_q;
  logic [CNT_W-1:0] blink_cnt_q;
  logic             blink_phase_q;

  logic [3:0]       nib_c;
  logic             blank_c;
  logic [4:0]       code_c;
  logic             mask_c;

  // Handshake status is a pure decode of the FSM state.
  assign in_ready    = (state_q == IDLE);
  assign busy        = ~in_ready;
  assign digit_codes = codes_q;

  // Select the nibble under scan and decide whether it is a leading zero.
  always_comb begin
    nib_c = 4'd0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == IDX_W'(k)) nib_c = shadow_q[4*k +: 4];
    end
    blank_c = lz_q & ~seen_nz_q & (nib_c == 4'd0) & (idx_q != '0);
    code_c  = blank_c ? BLANK : {1'b0, nib_c};
  end

  // Accept / scan / update FSM with its datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      lz_q      <= 1'b0;
      idx_q     <= '0;
      seen_nz_q <= 1'b0;
      staging_q <= BLANK_ALL;
      display_q <= BLANK_ALL;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shadow_q  <= in_data;
            lz_q      <= lz_blank_en;
            idx_q     <= IDX_TOP;
            seen_nz_q <= 1'b0;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) staging_q[5*k +: 5] <= code_c;
          end
          seen_nz_q <= seen_nz_q | (nib_c != 4'd0);
          if (idx_q == '0) begin
            state_q <= UPDATE;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        UPDATE: begin
          display_q <= staging_q;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Blink half-period counter; held cleared while blinking is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (!blink_en) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == CNT_TOP) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + CNT_W'(1);
    end
  end

  assign mask_c = ~disp_on | (blink_en & blink_phase_q);

  // Output stage applies global enable and blink masking every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codes_q <= BLANK_ALL;
    end else begin
      codes_q <= mask_c ? BLANK_ALL : display_q;
    end
  end

endmodule
